// File: rtl/systolic_mac_array.sv
// Output-stationary systolic MAC array: A operands stream right, B operands stream down,
// each PE accumulates the products of the operand pairs it sees, with elastic handshakes.
module systolic_mac_array #(
  parameter int unsigned width_p        = 32,
  parameter int unsigned array_width_p  = 2,
  parameter int unsigned array_height_p = 2
) (
  input  logic                                              clk_i,
  input  logic                                              reset_i,
  input  logic                                              en_i,
  input  logic [array_height_p-1:0]                         flush_i,
  input  logic [width_p*array_height_p-1:0]                 row_i,
  input  logic [array_height_p-1:0]                         row_valid_i,
  output logic [array_height_p-1:0]                         row_ready_o,
  input  logic [width_p*array_width_p-1:0]                  col_i,
  input  logic [array_width_p-1:0]                          col_valid_i,
  output logic [array_width_p-1:0]                          col_ready_o,
  output logic [width_p*array_width_p*array_height_p-1:0]   z_o,
  output logic [array_width_p*array_height_p-1:0]           z_valid_o,
  input  logic [array_width_p*array_height_p-1:0]           z_yumi_i
);

  localparam int unsigned W  = width_p;
  localparam int unsigned NC = array_width_p;
  localparam int unsigned NR = array_height_p;

  logic [W-1:0] r_a   [NR][NC];
  logic [W-1:0] r_b   [NR][NC];
  logic [W-1:0] r_acc [NR][NC];
  logic         r_av  [NR][NC];
  logic         r_bv  [NR][NC];
  logic         r_has [NR][NC];

  // Slot readiness has an extra column/row of constant-ready sinks past the array edge.
  logic         w_fire  [NR][NC];
  logic         w_a_rdy [NR][NC+1];
  logic         w_b_rdy [NR+1][NC];

  // Ready ripples back from the far edges, so evaluate bottom-right to top-left.
  always_comb begin
    for (int j = 0; j < int'(NR); j++) w_a_rdy[j][NC] = 1'b1;
    for (int k = 0; k < int'(NC); k++) w_b_rdy[NR][k] = 1'b1;
    for (int j = int'(NR) - 1; j >= 0; j--) begin
      for (int k = int'(NC) - 1; k >= 0; k--) begin
        w_fire[j][k]  = en_i & r_av[j][k] & r_bv[j][k] & w_a_rdy[j][k+1] & w_b_rdy[j+1][k];
        w_a_rdy[j][k] = en_i & (~r_av[j][k] | w_fire[j][k]);
        w_b_rdy[j][k] = en_i & (~r_bv[j][k] | w_fire[j][k]);
      end
    end
  end

  for (genvar gj = 0; gj < int'(NR); gj++) begin : g_row
    assign row_ready_o[gj] = w_a_rdy[gj][0];
  end

  for (genvar gk = 0; gk < int'(NC); gk++) begin : g_col
    assign col_ready_o[gk] = w_b_rdy[0][gk];
  end

  for (genvar gj = 0; gj < int'(NR); gj++) begin : g_pe_row
    for (genvar gk = 0; gk < int'(NC); gk++) begin : g_pe_col
      localparam int unsigned S = gk * NR + gj;

      logic [W-1:0] w_a_src;
      logic [W-1:0] w_b_src;
      logic         w_a_src_v;
      logic         w_b_src_v;
      logic [W-1:0] w_prod;
      logic         w_zv;
      logic         w_clr;

      // Edge PEs take operands from the ports; inner PEs from the neighbour that fires.
      if (gk == 0) begin : g_a_port
        assign w_a_src   = row_i[gj*W +: W];
        assign w_a_src_v = row_valid_i[gj];
      end else begin : g_a_hop
        assign w_a_src   = r_a[gj][gk-1];
        assign w_a_src_v = w_fire[gj][gk-1];
      end

      if (gj == 0) begin : g_b_port
        assign w_b_src   = col_i[gk*W +: W];
        assign w_b_src_v = col_valid_i[gk];
      end else begin : g_b_hop
        assign w_b_src   = r_b[gj-1][gk];
        assign w_b_src_v = w_fire[gj-1][gk];
      end

      assign w_prod = r_a[gj][gk] * r_b[gj][gk];
      assign w_zv   = r_has[gj][gk] & ~r_av[gj][gk] & ~r_bv[gj][gk];
      assign w_clr  = en_i & (flush_i[gj] | (z_yumi_i[S] & w_zv));

      assign z_o[S*W +: W] = r_acc[gj][gk];
      assign z_valid_o[S]  = w_zv;

      always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
          r_a[gj][gk]   <= '0;
          r_b[gj][gk]   <= '0;
          r_av[gj][gk]  <= 1'b0;
          r_bv[gj][gk]  <= 1'b0;
          r_acc[gj][gk] <= '0;
          r_has[gj][gk] <= 1'b0;
        end else begin
          if (w_a_rdy[gj][gk]) begin
            r_av[gj][gk] <= w_a_src_v;
            if (w_a_src_v) r_a[gj][gk] <= w_a_src;
          end
          if (w_b_rdy[gj][gk]) begin
            r_bv[gj][gk] <= w_b_src_v;
            if (w_b_src_v) r_b[gj][gk] <= w_b_src;
          end
          // A clear landing on a fire restarts the sum with the new product.
          if (w_fire[gj][gk]) begin
            r_acc[gj][gk] <= w_clr ? w_prod : r_acc[gj][gk] + w_prod;
            r_has[gj][gk] <= 1'b1;
          end else if (w_clr) begin
            r_acc[gj][gk] <= '0;
            r_has[gj][gk] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_mac_array.sv
// Directed bench for systolic_mac_array: a 2x2 and a 3x3 instance with hand-computed results.
module tb_systolic_mac_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         en;
  logic [1:0]   flush, rv, rr, cv, cr;
  logic [63:0]  row, col;
  logic [127:0] z;
  logic [3:0]   zv, yumi;

  logic [2:0]   flush3, rv3, rr3, cv3, cr3;
  logic [95:0]  row3, col3;
  logic [287:0] z3;
  logic [8:0]   zv3, yumi3;

  int checks = 0;
  int errors = 0;

  systolic_mac_array #(.width_p(32), .array_width_p(2), .array_height_p(2)) dut (
    .clk_i(clk), .reset_i(rst_n), .en_i(en), .flush_i(flush),
    .row_i(row), .row_valid_i(rv), .row_ready_o(rr),
    .col_i(col), .col_valid_i(cv), .col_ready_o(cr),
    .z_o(z), .z_valid_o(zv), .z_yumi_i(yumi)
  );

  systolic_mac_array #(.width_p(32), .array_width_p(3), .array_height_p(3)) dut3 (
    .clk_i(clk), .reset_i(rst_n), .en_i(en), .flush_i(flush3),
    .row_i(row3), .row_valid_i(rv3), .row_ready_o(rr3),
    .col_i(col3), .col_valid_i(cv3), .col_ready_o(cr3),
    .z_o(z3), .z_valid_o(zv3), .z_yumi_i(yumi3)
  );

  function automatic logic [31:0] zget(input int j, input int k);
    return z[32*(k*2+j) +: 32];
  endfunction

  function automatic logic [31:0] zget3(input int j, input int k);
    return z3[32*(k*3+j) +: 32];
  endfunction

  // Present one beat on the 2x2 lanes; each lane drops once accepted. Starts and ends at negedge.
  task automatic beat2(input logic [31:0] r0, r1, c0, c1, input logic [1:0] rm, cm, input int idle);
    logic [1:0] pr, pc, ar, ac;
    int cnt;
    pr = rm; pc = cm; cnt = 0;
    row = {r1, r0}; col = {c1, c0};
    while ((pr != 2'b00 || pc != 2'b00) && cnt < 50) begin
      rv = pr; cv = pc;
      #1;
      ar = pr & rr; ac = pc & cr;
      @(posedge clk);
      pr = pr & ~ar; pc = pc & ~ac;
      @(negedge clk);
      cnt++;
    end
    rv = 2'b00; cv = 2'b00;
    checks++;
    if (cnt >= 50) begin
      errors++;
      $display("FAIL beat2_accept pending row %b col %b after %0d cycles, required none", pr, pc, cnt);
    end
    repeat (idle) @(negedge clk);
  endtask

  task automatic beat3(input logic [95:0] r, c, input logic [2:0] rm, cm, input int idle);
    logic [2:0] pr, pc, ar, ac;
    int cnt;
    pr = rm; pc = cm; cnt = 0;
    row3 = r; col3 = c;
    while ((pr != 3'b000 || pc != 3'b000) && cnt < 50) begin
      rv3 = pr; cv3 = pc;
      #1;
      ar = pr & rr3; ac = pc & cr3;
      @(posedge clk);
      pr = pr & ~ar; pc = pc & ~ac;
      @(negedge clk);
      cnt++;
    end
    rv3 = 3'b000; cv3 = 3'b000;
    checks++;
    if (cnt >= 50) begin
      errors++;
      $display("FAIL beat3_accept pending row %b col %b after %0d cycles, required none", pr, pc, cnt);
    end
    repeat (idle) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check4(input string name, input logic [31:0] e00, e01, e10, e11);
    logic [31:0] ex [2][2];
    ex[0][0] = e00; ex[0][1] = e01; ex[1][0] = e10; ex[1][1] = e11;
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (zget(j, k) !== ex[j][k]) begin
          errors++;
          $display("FAIL %s z[%0d][%0d] got %0d required %0d", name, j, k,
                   $signed(zget(j, k)), $signed(ex[j][k]));
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (z !== '0 || zv !== 4'b0000) begin
      errors++; $display("FAIL reset_z got zv %b z %h required zeros", zv, z);
    end
    checks++;
    if (rr !== 2'b00 || cr !== 2'b00) begin
      errors++; $display("FAIL reset_ready_en0 got %b/%b required 00/00", rr, cr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rr !== 2'b00 || cr !== 2'b00) begin
      errors++; $display("FAIL ready_en0 got %b/%b required 00/00", rr, cr);
    end
    en = 1'b1;
    #1;
    checks++;
    if (rr !== 2'b11 || cr !== 2'b11) begin
      errors++; $display("FAIL ready_en1 got %b/%b required 11/11", rr, cr);
    end
    @(negedge clk);
  endtask

  task automatic test_skew_a();
    beat2(32'd44, 32'd0, 32'd22, 32'd0, 2'b01, 2'b01, 8);
    beat2(32'(-37), 32'd960, 32'd83, 32'(-1), 2'b11, 2'b11, 8);
    beat2(32'd0, 32'd10, 32'd0, 32'd99, 2'b10, 2'b10, 8);
    checks++;
    if (zv !== 4'b1111) begin
      errors++; $display("FAIL skew_a_valid got %b required 1111", zv);
    end
    check4("skew_a", 32'(-2103), 32'(-3707), 32'd21950, 32'd30);
  endtask

  task automatic test_flush();
    flush = 2'b01;
    @(negedge clk);
    flush = 2'b00;
    checks++;
    if (zv !== 4'b1010) begin
      errors++; $display("FAIL flush_valid got %b required 1010", zv);
    end
    check4("flush", 32'd0, 32'd0, 32'd21950, 32'd30);
  endtask

  task automatic test_yumi();
    yumi = 4'b1001;
    @(negedge clk);
    yumi = 4'b0000;
    checks++;
    if (zv !== 4'b0010) begin
      errors++; $display("FAIL yumi_valid got %b required 0010", zv);
    end
    check4("yumi", 32'd0, 32'd0, 32'd21950, 32'd0);
  endtask

  task automatic test_skew_b();
    do_reset();
    beat2(32'd45, 32'd0, 32'd22, 32'd0, 2'b01, 2'b01, 8);
    beat2(32'd13, 32'd27, 32'd83, 32'd1, 2'b11, 2'b11, 8);
    beat2(32'd0, 32'd6, 32'd0, 32'd9, 2'b10, 2'b10, 8);
    checks++;
    if (zv !== 4'b1111) begin
      errors++; $display("FAIL skew_b_valid got %b required 1111", zv);
    end
    check4("skew_b", 32'd2069, 32'd162, 32'd1092, 32'd81);
  endtask

  task automatic test_backpressure();
    do_reset();
    beat2(32'd5, 32'd0, 32'd0, 32'd0, 2'b01, 2'b00, 2);
    row = {32'd0, 32'd7}; rv = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rr[0] !== 1'b0) begin
        errors++; $display("FAIL bp_stall cycle %0d row_ready got %b required 0", i, rr[0]);
      end
      @(negedge clk);
    end
    beat2(32'd7, 32'd1, 32'd3, 32'd1, 2'b11, 2'b11, 0);
    beat2(32'd0, 32'd1, 32'd4, 32'd1, 2'b10, 2'b11, 8);
    checks++;
    if (zv !== 4'b1111) begin
      errors++; $display("FAIL bp_valid got %b required 1111", zv);
    end
    check4("bp", 32'd43, 32'd12, 32'd7, 32'd2);
  endtask

  task automatic test_en_hold();
    en = 1'b0; flush = 2'b11; yumi = 4'b1111;
    row = {32'd9, 32'd9}; col = {32'd9, 32'd9}; rv = 2'b11; cv = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (rr !== 2'b00 || cr !== 2'b00) begin
        errors++; $display("FAIL en_hold_ready cycle %0d got %b/%b required 00/00", i, rr, cr);
      end
      @(negedge clk);
    end
    en = 1'b1; flush = 2'b00; yumi = 4'b0000; rv = 2'b00; cv = 2'b00;
    #1;
    checks++;
    if (zv !== 4'b1111) begin
      errors++; $display("FAIL en_hold_valid got %b required 1111", zv);
    end
    check4("en_hold", 32'd43, 32'd12, 32'd7, 32'd2);
    @(negedge clk);
  endtask

  task automatic test_wrap();
    do_reset();
    beat2(32'h7FFF_FFFF, 32'd0, 32'd2, 32'd0, 2'b01, 2'b01, 4);
    checks++;
    if (zget(0, 0) !== 32'hFFFF_FFFE || zv[0] !== 1'b1) begin
      errors++; $display("FAIL wrap got %h valid %b required fffffffe valid 1", zget(0, 0), zv[0]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    row = {32'd0, 32'd6}; col = {32'd0, 32'd7}; rv = 2'b01; cv = 2'b01;
    @(negedge clk);
    rv = 2'b00; cv = 2'b00;
    @(negedge clk);
    checks++;
    if (zget(0, 0) !== 32'd42) begin
      errors++; $display("FAIL mid_pre_reset got %0d required 42", $signed(zget(0, 0)));
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (z !== '0 || zv !== 4'b0000) begin
      errors++; $display("FAIL mid_reset got zv %b z %h required zeros", zv, z);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_3x3();
    int a3 [3][3];
    int b3 [3][3];
    int c3 [3][3];
    logic [95:0] r, c;
    a3 = '{'{70, -17, -43}, '{-58, -7, 40}, '{61, -14, -5}};
    b3 = '{'{-7, 43, -99}, '{30, 98, -93}, '{-8, 91, -31}};
    c3 = '{'{-656, -2569, -4016}, '{-124, 460, 5153}, '{-807, 796, -4582}};
    for (int i = 0; i < 3; i++) begin
      for (int l = 0; l < 3; l++) begin
        r[32*l +: 32] = 32'(a3[l][i]);
        c[32*l +: 32] = 32'(b3[i][l]);
      end
      beat3(r, c, 3'b111, 3'b111, 0);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (zv3 !== 9'h1FF) begin
      errors++; $display("FAIL mm3_valid got %b required 111111111", zv3);
    end
    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (zget3(j, k) !== 32'(c3[j][k])) begin
          errors++;
          $display("FAIL mm3 z[%0d][%0d] got %0d required %0d", j, k, $signed(zget3(j, k)), c3[j][k]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0;
    flush = '0; rv = '0; cv = '0; row = '0; col = '0; yumi = '0;
    flush3 = '0; rv3 = '0; cv3 = '0; row3 = '0; col3 = '0; yumi3 = '0;
    test_reset();
    test_skew_a();
    test_flush();
    test_yumi();
    test_skew_b();
    test_backpressure();
    test_en_hold();
    test_wrap();
    test_reset_mid();
    test_3x3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_mac_array.md
# systolic_mac_array

Output-stationary 2-D systolic multiply-accumulate array of `array_height_p` × `array_width_p` processing elements (PEs) that computes matrix products.
- Row operands (A elements) enter on the left edge and move right, one PE per cycle.
- Column operands (B elements) enter on the top edge and move down.
- Each PE multiplies each operand pair it meets and adds the product to its own accumulator.
- Sits between the operand-staging logic and the result-drain logic of the matrix engine; elastic valid/ready handshakes allow sparse, skewed operand injection.

## Interface
Parameters:
- `width_p`, 32, operand/accumulator width (two's complement)
- `array_width_p`, 2, PE columns (number of column inputs)
- `array_height_p`, 2, PE rows (number of row inputs)

Ports:
- `clk_i`  in  1  single clock, all state on rising edge
- `reset_i`  in  1  asynchronous, active-low reset
- `en_i`  in  1  global enable; low freezes all state and forces every ready low
- `flush_i`  in  `array_height_p`  bit j synchronously clears all accumulators of PE row j
- `row_i`  in  `width_p*array_height_p`  row operands; row j at bits [width_p*(j+1)-1 : width_p*j]
- `row_valid_i`  in  `array_height_p`  per-row valid
- `row_ready_o`  out  `array_height_p`  per-row ready
- `col_i`  in  `width_p*array_width_p`  column operands; column k at bits [width_p*(k+1)-1 : width_p*k]
- `col_valid_i` / `col_ready_o`  in/out  `array_width_p`  per-column handshake
- `z_o`  out  `width_p*array_width_p*array_height_p`  accumulators; PE(j,k) at slot s = k*array_height_p + j, bits [width_p*(s+1)-1 : width_p*s]
- `z_valid_o`  out  `array_width_p*array_height_p`  per-slot result valid
- `z_yumi_i`  in  `array_width_p*array_height_p`  per-slot result consume

## Operation
PE(j,k) state:
- `a`/`a_v`: row operand register and its valid bit.
- `b`/`b_v`: column operand register and its valid bit.
- `acc` (width_p) and `has_data`.

Firing rule:
- `fire` = en_i & a_v & b_v & right_rdy & down_rdy.
- `right_rdy` is PE(j,k+1)'s a-slot ready; `down_rdy` is PE(j+1,k)'s b-slot ready.
- PEs in the last column/row discard their forwarded operand, so that ready is 1.

Slot readiness:
- a-slot ready = en_i & (!a_v | fire); b-slot likewise.
- `row_ready_o[j]` = a-slot ready of PE(j,0); `col_ready_o[k]` = b-slot ready of PE(0,k).

Transfers and accumulation:
- A transfer happens when valid & ready. Sources hold data until accepted; unaccepted data is not captured.
- On fire: acc <= acc + a*b, has_data <= 1; a moves to PE(j,k+1), b moves to PE(j+1,k); the local slots empty unless refilled in the same cycle.
- Arithmetic: product and sum truncated to low width_p bits (wrap modulo 2^width_p, signed interpretation).

Results and clearing:
- `z_o` slot = acc, driven straight from the register.
- `z_valid_o[s]` = has_data & !a_v & !b_v.
- Clear: on flush_i[j] (any PE of row j) or on z_yumi_i[s] & z_valid_o[s], acc <= 0 and has_data <= 0.
- If a clear coincides with fire: acc <= a*b, has_data <= 1.
- z_yumi_i without z_valid_o is ignored.
- Operands still in flight are unaffected by flush.

## Timing
- Reset (reset_i low, asynchronous): all a_v/b_v/has_data = 0, acc = 0, so z_o = 0 and z_valid_o = 0.
- After reset: ready outputs are 0 while en_i = 0, and 1 once en_i = 1.
- Operand accepted at edge t is in PE(j,0)/PE(0,k) after t. It can fire at edge t+1 if its partner is present.
- Each hop costs one cycle. A pair injected into an empty array reaches PE(H-1,W-1) after H+W-2 hops.
- A full pass drains within 2·W·H cycles of the last accepted operand.
- Readiness is pipeline-style, so a fully streaming row/column sustains one operand per cycle.
- Simultaneous fire-and-refill of a slot is allowed.
- A waiting operand blocks its upstream chain (backpressure) and is never overwritten.
- en_i low: no transfers, no fires, no clears; state is retained.

## Test plan
- Skewed 2x2, A=[[-37,44],[10,960]], B=[[83,99],[22,-1]], operand beats each followed by 8 idle cycles:
  - Beats: (row0=44,col0=22, valid 01), then (row0=-37,row1=960,col0=83,col1=-1, valid 11), then (row1=10,col1=99, valid 10).
  - Required: z_valid_o=1111; z[0][0]=-2103, z[0][1]=-3707, z[1][0]=21950, z[1][1]=30.
- Same skew after reset, A=[[13,45],[6,27]], B=[[83,9],[22,1]] -> z[0][0]=2069, z[0][1]=162, z[1][0]=1092, z[1][1]=81.
- 3x3, A=[[70,-17,-43],[-58,-7,40],[61,-14,-5]], B=[[-7,43,-99],[30,98,-93],[-8,91,-31]] -> [[-656,-2569,-4016],[-124,460,5153],[-807,796,-4582]].
- Backpressure:
  - Inject row0 twice with no column data: second beat sees row_ready_o[0]=0 until a col0 beat arrives; no value is lost.
  - Next, en_i=0 for 5 cycles: all state held.
- Clearing:
  - flush_i=01 after test 1: row0 slots = 0 with z_valid_o low; row1 retained.
  - z_yumi_i on slot 3: z[1][1] -> 0 next cycle.
  - Assert reset_i low mid-pass: all outputs 0 immediately.
- Wrap: 0x7FFFFFFF*2 in a single PE -> acc = 0xFFFFFFFE.
